// File: rtl/adt7420_i2c_responder.sv
// ADT7420-compatible I2C target: oversampled SCL/SDA, pointer/config/ID register map, open-drain SDA.
// Build option: define ADT7420_RESP_AUTOINC_EN to advance the pointer after every data byte.
`timescale 1ns/1ps

module adt7420_i2c_responder #(
  parameter logic [6:0] DEV_ADDR = 7'h48,
  parameter int         HOLD_CYC = 4
) (
  input  logic        ILA_Clk,
  input  logic        Reset_n,
  input  logic        SCL_in,
  input  logic        SDA_in,
  output logic        SDA_oe,
  input  logic [15:0] Temp_in,
  output logic [7:0]  Config_out,
  output logic [7:0]  State,
  output logic        Addr_match,
  output logic        Busy
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR      = 4'd1,
    ADDR_ACK  = 4'd2,
    PTR       = 4'd3,
    PTR_ACK   = 4'd4,
    WDATA     = 4'd5,
    WDATA_ACK = 4'd6,
    TX        = 4'd7,
    TX_ACK    = 4'd8,
    WAIT_STOP = 4'd9
  } state_t;

  localparam logic [7:0] HOLD_LD = 8'(HOLD_CYC);

  state_t      state_q;
  logic        scl_p0, scl_p1, scl_p2;
  logic        sda_p0, sda_p1, sda_p2;
  logic [2:0]  bit_cnt;
  logic [7:0]  ptr_q;
  logic [7:0]  config_q;
  logic [7:0]  hold_cnt;
  logic        hold_act;
  logic [7:0]  shift_q;
  logic [7:0]  tx_q;
  logic [15:0] snap_q;
  logic        rw_q;

  logic        scl_rise, scl_fall, start_evt, stop_evt;
  logic [7:0]  rx_byte;
  logic        byte_done, addr_hit, tx_load, oe_target;

  function automatic logic [7:0] rd_reg(input logic [7:0] p, input logic [15:0] t,
                                        input logic [7:0] c);
    case (p)
      8'h00:   return t[15:8];
      8'h01:   return t[7:0];
      8'h03:   return c;
      8'h0B:   return 8'hCB;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] ptr_next(input logic [7:0] p);
`ifdef ADT7420_RESP_AUTOINC_EN
    return (p == 8'h0F) ? 8'h00 : p + 8'h01;
`else
    return p;
`endif
  endfunction

  // Events need SCL stable high across both samples, so simultaneous SCL/SDA changes are plain data.
  assign scl_rise  = scl_p1 & ~scl_p2;
  assign scl_fall  = ~scl_p1 & scl_p2;
  assign start_evt = scl_p1 & scl_p2 & sda_p2 & ~sda_p1;
  assign stop_evt  = scl_p1 & scl_p2 & ~sda_p2 & sda_p1;
  assign rx_byte   = {shift_q[6:0], sda_p1};
  assign byte_done = (bit_cnt == 3'd7);
  assign addr_hit  = (rx_byte[7:1] == DEV_ADDR);
  assign tx_load   = ((state_q == ADDR_ACK) && rw_q) || ((state_q == TX_ACK) && !sda_p1);

  always_comb begin
    oe_target = 1'b0;
    case (state_q)
      ADDR_ACK, PTR_ACK, WDATA_ACK: oe_target = 1'b1;
      TX:                           oe_target = ~tx_q[7];
      default:                      oe_target = 1'b0;
    endcase
  end

  assign State      = {4'h0, state_q};
  assign Config_out = config_q;

  // Stage p0/p1: two-flop synchronizer; p2: previous sample for edge detection
  always_ff @(posedge ILA_Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      scl_p0     <= 1'b1;
      scl_p1     <= 1'b1;
      scl_p2     <= 1'b1;
      sda_p0     <= 1'b1;
      sda_p1     <= 1'b1;
      sda_p2     <= 1'b1;
      state_q    <= IDLE;
      bit_cnt    <= 3'd0;
      ptr_q      <= 8'h00;
      config_q   <= 8'h00;
      hold_cnt   <= 8'h00;
      hold_act   <= 1'b0;
      SDA_oe     <= 1'b0;
      Addr_match <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      scl_p0     <= SCL_in;
      scl_p1     <= scl_p0;
      scl_p2     <= scl_p1;
      sda_p0     <= SDA_in;
      sda_p1     <= sda_p0;
      sda_p2     <= sda_p1;
      Addr_match <= 1'b0;
      if (stop_evt) begin
        state_q  <= IDLE;
        SDA_oe   <= 1'b0;
        Busy     <= 1'b0;
        hold_act <= 1'b0;
      end else if (start_evt) begin
        state_q  <= ADDR;
        bit_cnt  <= 3'd0;
        SDA_oe   <= 1'b0;
        hold_act <= 1'b0;
      end else begin
        // SDA only ever moves HOLD_CYC cycles into the SCL low phase
        if (scl_fall) begin
          hold_act <= 1'b1;
          hold_cnt <= HOLD_LD;
        end else if (hold_act) begin
          if (hold_cnt <= 8'd1) begin
            hold_act <= 1'b0;
            SDA_oe   <= oe_target;
            if (state_q == ADDR_ACK && !SDA_oe) Addr_match <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt - 8'd1;
          end
        end
        if (scl_rise) begin
          case (state_q)
            ADDR: begin
              bit_cnt <= bit_cnt + 3'd1;
              if (byte_done) begin
                state_q <= addr_hit ? ADDR_ACK : WAIT_STOP;
                Busy    <= addr_hit;
              end
            end
            ADDR_ACK: begin
              bit_cnt <= 3'd0;
              state_q <= rw_q ? TX : PTR;
            end
            PTR: begin
              bit_cnt <= bit_cnt + 3'd1;
              if (byte_done) begin
                ptr_q   <= rx_byte;
                state_q <= PTR_ACK;
              end
            end
            PTR_ACK, WDATA_ACK: begin
              bit_cnt <= 3'd0;
              state_q <= WDATA;
            end
            WDATA: begin
              bit_cnt <= bit_cnt + 3'd1;
              if (byte_done) begin
                if (ptr_q == 8'h03) config_q <= rx_byte;
                ptr_q   <= ptr_next(ptr_q);
                state_q <= WDATA_ACK;
              end
            end
            TX: begin
              bit_cnt <= bit_cnt + 3'd1;
              if (byte_done) begin
                ptr_q   <= ptr_next(ptr_q);
                state_q <= TX_ACK;
              end
            end
            TX_ACK: begin
              bit_cnt <= 3'd0;
              state_q <= sda_p1 ? WAIT_STOP : TX;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Data path: receive shifter, transmit shifter and the read-coherent temperature snapshot
  always_ff @(posedge ILA_Clk) begin
    if (scl_rise) begin
      shift_q <= rx_byte;
      if (state_q == ADDR && byte_done) begin
        rw_q <= rx_byte[0];
        if (addr_hit && rx_byte[0]) snap_q <= Temp_in;
      end
      if (tx_load) tx_q <= rd_reg(ptr_q, snap_q, config_q);
      else if (state_q == TX) tx_q <= {tx_q[6:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_adt7420_i2c_responder.sv
// Bench for adt7420_i2c_responder: bit-level I2C master, register table, directed corners, random transactions.
`timescale 1ns/1ps

module tb_adt7420_i2c_responder;

  localparam int         H   = 12;
  localparam logic [6:0] DEV = 7'h48;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scl = 1'b1;
  logic        sda_m = 1'b1;
  logic [15:0] temp = 16'h0000;
  logic        sda_oe, addr_match, busy;
  logic [7:0]  cfg_out, state;
  logic        sda_pad;

  assign sda_pad = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  adt7420_i2c_responder #(.DEV_ADDR(DEV), .HOLD_CYC(4)) dut (
    .ILA_Clk(clk), .Reset_n(rst_n), .SCL_in(scl), .SDA_in(sda_pad), .SDA_oe(sda_oe),
    .Temp_in(temp), .Config_out(cfg_out), .State(state), .Addr_match(addr_match), .Busy(busy)
  );

  int vectors = 0, miscompares = 0;
  int am_cnt = 0, oe_cnt = 0;

  always @(posedge clk) begin
    if (addr_match) am_cnt <= am_cnt + 1;
    if (sda_oe) oe_cnt <= oe_cnt + 1;
  end

  // Reference model: register contents and pointer tracked per transaction
  logic [7:0] m_ptr = 8'h00;
  logic [7:0] m_cfg = 8'h00;

  function automatic logic [7:0] m_read(input logic [7:0] p, input logic [15:0] t);
    logic [7:0] map [0:15];
    foreach (map[i]) map[i] = 8'h00;
    map[0]  = t[15:8];
    map[1]  = t[7:0];
    map[3]  = m_cfg;
    map[11] = 8'hCB;
    return (p < 8'd16) ? map[p[3:0]] : 8'h00;
  endfunction

  function automatic logic [7:0] adv(input logic [7:0] p);
`ifdef ADT7420_RESP_AUTOINC_EN
    return (p == 8'h0F) ? 8'h00 : p + 8'h01;
`else
    return p;
`endif
  endfunction

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    wait_clk(H/2);
    scl = 1'b1;
    wait_clk(H/2);
    sda_m = 1'b0;
    wait_clk(H/2);
    scl = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clk(2);
    sda_m = 1'b0;
    wait_clk(H);
    scl = 1'b1;
    wait_clk(H/2);
    sda_m = 1'b1;
    wait_clk(H/2);
  endtask

  task automatic i2c_bit(input logic b, output logic smp);
    wait_clk(2);
    sda_m = b;
    wait_clk(H-2);
    scl = 1'b1;
    wait_clk(H/2);
    smp = sda_pad;
    wait_clk(H/2);
    scl = 1'b0;
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) i2c_bit(d[i], s);
    i2c_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic rd_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      i2c_bit(1'b1, s);
      d[i] = s;
    end
    i2c_bit(~mack, s);
  endtask

  task automatic do_write(input logic [6:0] a, input logic [7:0] p, input int n,
                          input logic [7:0] d0, input logic [7:0] d1);
    logic ack, hit;
    logic [7:0] d;
    hit = (a == DEV);
    i2c_start();
    wr_byte({a, 1'b0}, ack);
    check("wr_addr_ack", ack, hit);
    if (hit) begin
      check("wr_busy", busy, 1'b1);
      wr_byte(p, ack);
      check("wr_ptr_ack", ack, 1'b1);
      m_ptr = p;
      for (int k = 0; k < n; k++) begin
        d = (k == 0) ? d0 : d1;
        wr_byte(d, ack);
        check("wr_data_ack", ack, 1'b1);
        if (m_ptr == 8'h03) m_cfg = d;
        m_ptr = adv(m_ptr);
      end
    end else begin
      wait_clk(H-2);
      check("wr_nohit_busy", busy, 1'b0);
      check("wr_nohit_state", state, 8'd9);
    end
    i2c_stop();
    check("wr_cfg", cfg_out, m_cfg);
    check("wr_idle", state, 8'd0);
  endtask

  task automatic do_read(input logic [6:0] a, input logic set_p, input logic [7:0] p, input int n,
                         input logic [15:0] t_mid, output logic [7:0] b0, output logic [7:0] b1);
    logic ack, hit;
    logic [7:0] d;
    logic [15:0] snap;
    b0 = 8'h00;
    b1 = 8'h00;
    hit = (a == DEV);
    if (set_p) begin
      i2c_start();
      wr_byte(8'h90, ack);
      check("rd_set_addr_ack", ack, 1'b1);
      wr_byte(p, ack);
      check("rd_set_ptr_ack", ack, 1'b1);
      m_ptr = p;
    end
    i2c_start();
    wr_byte({a, 1'b1}, ack);
    check("rd_addr_ack", ack, hit);
    if (hit) begin
      snap = temp;
      check("rd_busy", busy, 1'b1);
      for (int k = 0; k < n; k++) begin
        rd_byte(1'(k < n - 1), d);
        check("rd_data", d, m_read(m_ptr, snap));
        if (k == 0) b0 = d;
        if (k == 1) b1 = d;
        m_ptr = adv(m_ptr);
        if (k == 0) temp = t_mid;
      end
      wait_clk(H-2);
      check("rd_release", sda_oe, 1'b0);
    end else begin
      wait_clk(H-2);
      check("rd_nohit_busy", busy, 1'b0);
    end
    check("rd_wait_stop", state, 8'd9);
    i2c_stop();
    check("rd_idle", state, 8'd0);
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] ptr;
    logic [7:0] dat;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [11];

  initial begin
    logic [7:0] b0, b1;
    logic ack, s;
    int am0, oe0, kind, n;
    logic [6:0] a;

    tbl[0]  = '{1'b1, 8'h03, 8'h5A, 8'h5A};
    tbl[1]  = '{1'b1, 8'h02, 8'h77, 8'h5A};
    tbl[2]  = '{1'b1, 8'h0B, 8'h11, 8'h5A};
    tbl[3]  = '{1'b0, 8'h0B, 8'h00, 8'hCB};
    tbl[4]  = '{1'b0, 8'h02, 8'h00, 8'h00};
    tbl[5]  = '{1'b0, 8'h03, 8'h00, 8'h5A};
    tbl[6]  = '{1'b0, 8'h00, 8'h00, 8'hAB};
    tbl[7]  = '{1'b0, 8'h01, 8'h00, 8'hCD};
    tbl[8]  = '{1'b0, 8'h07, 8'h00, 8'h00};
    tbl[9]  = '{1'b1, 8'h03, 8'hA5, 8'hA5};
    tbl[10] = '{1'b0, 8'h03, 8'h00, 8'hA5};

    wait_clk(4);
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_cfg", cfg_out, 8'h00);
    check("rst_state", state, 8'd0);
    check("rst_addr_match", addr_match, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    wait_clk(4);

    // Config write with a single address-match pulse
    am0 = am_cnt;
    do_write(DEV, 8'h03, 1, 8'h5A, 8'h00);
    check("cfg_5a", cfg_out, 8'h5A);
    check("addr_match_pulses", 16'(am_cnt - am0), 16'd1);

    // Register table
    temp = 16'hABCD;
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].wr) begin
        do_write(DEV, tbl[i].ptr, 1, tbl[i].dat, 8'h00);
        check("tbl_cfg", cfg_out, tbl[i].exp);
      end else begin
        do_read(DEV, 1'b1, tbl[i].ptr, 1, temp, b0, b1);
        check("tbl_rd", b0, tbl[i].exp);
      end
    end

    // Two-byte read with Temp_in moving between the bytes
    temp = 16'h0C80;
    do_read(DEV, 1'b1, 8'h00, 2, 16'h0D00, b0, b1);
    check("temp_msb", b0, 8'h0C);
`ifdef ADT7420_RESP_AUTOINC_EN
    check("temp_lsb", b1, 8'h80);
`else
    check("temp_repeat", b1, 8'h0C);
`endif

    // ID register read twice
    do_read(DEV, 1'b1, 8'h0B, 2, temp, b0, b1);
    check("id_first", b0, 8'hCB);
`ifdef ADT7420_RESP_AUTOINC_EN
    check("id_next", b1, 8'h00);
`else
    check("id_repeat", b1, 8'hCB);
`endif

    // Foreign address: SDA never pulled
    oe0 = oe_cnt;
    do_write(7'h49, 8'h03, 1, 8'h11, 8'h00);
    check("nohit_oe_cycles", 16'(oe_cnt - oe0), 16'd0);

    // Reset while driving a 0 data bit, then clock a byte without START
    do_write(DEV, 8'h02, 0, 8'h00, 8'h00);
    i2c_start();
    wr_byte(8'h91, ack);
    check("mid_tx_addr_ack", ack, 1'b1);
    wait_clk(H-2);
    check("mid_tx_oe", sda_oe, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_oe", sda_oe, 1'b0);
    check("mid_rst_state", state, 8'd0);
    check("mid_rst_busy", busy, 1'b0);
    wait_clk(2);
    rst_n = 1'b1;
    m_ptr = 8'h00;
    m_cfg = 8'h00;
    check("mid_rst_cfg", cfg_out, 8'h00);
    oe0 = oe_cnt;
    for (int i = 7; i >= 0; i--) i2c_bit(1'(8'h90 >> i), s);
    i2c_bit(1'b1, s);
    check("no_start_oe_cycles", 16'(oe_cnt - oe0), 16'd0);
    check("no_start_state", state, 8'd0);
    i2c_stop();
    temp = 16'h1234;
    do_read(DEV, 1'b0, 8'h00, 1, temp, b0, b1);
    check("ptr_after_rst", b0, 8'h12);

    // Random transactions against the model
    for (int it = 0; it < 25; it++) begin
      a = ($urandom_range(0, 4) == 0) ? 7'($urandom_range(0, 127)) : DEV;
      temp = 16'($urandom);
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        n = $urandom_range(0, 2);
        do_write(a, 8'($urandom_range(0, 15)), n, 8'($urandom), 8'($urandom));
      end else begin
        n = $urandom_range(1, 3);
        do_read(a, 1'(kind == 2), 8'($urandom_range(0, 15)), n, 16'($urandom), b0, b1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
